// File: rtl/fx2_dac_pkg.sv
// fx2_dac_pkg: shared definitions for the FX2LP-fed DAC sequencer.
//   - seq_state_e  : sequencer state encoding, also reported in status[1:0]
//   - CTRL_*       : bit positions inside the cfg_ctrl word (pio_0)
//   - STAT_*       : field positions inside the status readback word
//   - midscale()   : offset-binary zero code for a given DAC width
package fx2_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFILL  = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } seq_state_e;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_HOLD_BIT   = 1;
    localparam int unsigned CTRL_CLEAR_BIT  = 2;
    localparam int unsigned CTRL_THR_LSB    = 8;
    localparam int unsigned CTRL_THR_W      = 8;

    localparam int unsigned STAT_STATE_LSB  = 0;
    localparam int unsigned STAT_EMPTY_BIT  = 2;
    localparam int unsigned STAT_FULL_BIT   = 3;
    localparam int unsigned STAT_UCNT_LSB   = 16;
    localparam int unsigned STAT_UCNT_W     = 16;

    function automatic logic [31:0] midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fx2_dac_sequencer_sample_fifo.sv
// sample_fifo: synchronous FIFO holding DAC_W-bit samples already selected
// from the FX2 data bus.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the FIFO (pointers and count to zero)
//   push_i/wdata_i write one sample
//   pop_i/rdata_o  rdata_o always shows the head; pop_i advances it
//   count_o        number of stored samples (0..FIFO_DEPTH)
//   empty_o/full_o occupancy flags
module sample_fifo #(
    parameter int unsigned DAC_W      = 14,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [DAC_W-1:0]                wdata_i,
    input  logic                            pop_i,
    output logic [DAC_W-1:0]                rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            empty_o,
    output logic                            full_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DAC_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(FIFO_DEPTH));

endmodule

// File: rtl/fx2_dac_sequencer.sv
// fx2_dac_sequencer: pulls 16-bit words from the FX2LP slave FIFO into a
// local buffer and releases one DAC sample per programmed rate tick.
// Ports:
//   clk_clk, reset_reset     clock (also FX2 IFCLK), sync active-high reset
//   cfg_ctrl                 [0] enable, [1] hold_last, [2] clear_status,
//                            [15:8] prefill threshold
//   cfg_rate                 sample period minus one, in clocks
//   fx2_empty_n, fx2_fd      FX2 endpoint flag and data
//   fx2_slrd_n, fx2_sloe_n   FX2 read strobe / output enable (active low)
//   fx2_fifoadr              endpoint select, constant FX2_EP
//   dac_data, dac_valid      DAC code (offset binary) and new-sample strobe
//   status                   [1:0] state, [2] fifo_empty, [3] fifo_full,
//                            [31:16] underrun count
// Build option: define SIGNED_INPUT_EN when the FX2 stream carries two's
// complement samples; the sample MSB is then inverted on the way out.
module fx2_dac_sequencer
    import fx2_dac_pkg::*;
#(
    parameter int unsigned DAC_W      = 14,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RATE_W     = 24,
    parameter logic [1:0]  FX2_EP     = 2'b10
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [31:0]       cfg_ctrl,
    input  logic [31:0]       cfg_rate,
    input  logic              fx2_empty_n,
    input  logic [15:0]       fx2_fd,
    output logic              fx2_slrd_n,
    output logic              fx2_sloe_n,
    output logic [1:0]        fx2_fifoadr,
    output logic [DAC_W-1:0]  dac_data,
    output logic              dac_valid,
    output logic [31:0]       status
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

    seq_state_e        state_q, state_d;
    logic              slrd_n_q, slrd_n_d;
    logic              sloe_n_q, sloe_n_d;
    logic [DAC_W-1:0]  dac_q, dac_d;
    logic              valid_q, valid_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              clr_q;
    logic [31:0]       status_q, status_d;

    logic              en, hold, clr_rise, tick, room;
    logic [31:0]       thr;
    logic              push, pop, flush;
    logic [DAC_W-1:0]  fifo_rdata;
    logic [CW-1:0]     fifo_count, cnt_nxt;
    logic              fifo_empty, fifo_full;

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg_ctrl[31:16], cfg_ctrl[7:3],
                               cfg_rate[31:RATE_W], fx2_fd[15-DAC_W:0]};

    function automatic logic [DAC_W-1:0] to_dac_code(input logic [DAC_W-1:0] w);
`ifdef SIGNED_INPUT_EN
        return w ^ MID;
`else
        return w;
`endif
    endfunction

    sample_fifo #(
        .DAC_W      (DAC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (fx2_fd[15 -: DAC_W]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign en       = cfg_ctrl[CTRL_ENABLE_BIT];
    assign hold     = cfg_ctrl[CTRL_HOLD_BIT];
    assign clr_rise = cfg_ctrl[CTRL_CLEAR_BIT] && !clr_q;
    assign tick     = (rate_q == '0);
    // Two free slots are required because the previous read may still land.
    assign room     = (32'(fifo_count) + 32'd2) <= FIFO_DEPTH;

    always_comb begin
        thr = 32'(cfg_ctrl[CTRL_THR_LSB +: CTRL_THR_W]);
        if (thr == 32'd0) begin
            thr = 32'd1;
        end else if (thr > FIFO_DEPTH) begin
            thr = FIFO_DEPTH;
        end
    end

    always_comb begin
        state_d  = state_q;
        slrd_n_d = 1'b1;
        dac_d    = dac_q;
        valid_d  = 1'b0;
        ucnt_d   = ucnt_q;
        rate_d   = rate_q;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
            dac_d   = MID;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_PREFILL;
            flush   = 1'b1;
            dac_d   = MID;
        end else begin
            // The word strobed during the low cycle is captured on this edge.
            push = !slrd_n_q;
            if (slrd_n_q && fx2_empty_n && room) begin
                slrd_n_d = 1'b0;
            end
            case (state_q)
                ST_PREFILL: begin
                    if (32'(fifo_count) >= thr) begin
                        state_d = ST_RUN;
                        rate_d  = cfg_rate[RATE_W-1:0];
                    end
                end
                default: begin
                    rate_d = tick ? cfg_rate[RATE_W-1:0] : rate_q - RATE_W'(1);
                    if (tick) begin
                        valid_d = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            dac_d   = to_dac_code(fifo_rdata);
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_UNDERRUN;
                            if (ucnt_q != 16'hFFFF) begin
                                ucnt_d = ucnt_q + 16'd1;
                            end
                            if (!hold) begin
                                dac_d = MID;
                            end
                        end
                    end
                end
            endcase
        end

        if (clr_rise) begin
            ucnt_d = '0;
        end

        sloe_n_d = (state_d == ST_IDLE);
    end

    // Status is registered from next-state values so it tracks the live
    // state while still reading zero during reset.
    always_comb begin
        cnt_nxt  = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
        status_d = '0;
        status_d[STAT_STATE_LSB +: 2]           = state_d;
        status_d[STAT_EMPTY_BIT]                = (cnt_nxt == '0);
        status_d[STAT_FULL_BIT]                 = (cnt_nxt == CW'(FIFO_DEPTH));
        status_d[STAT_UCNT_LSB +: STAT_UCNT_W]  = ucnt_d;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q  <= ST_IDLE;
            slrd_n_q <= 1'b1;
            sloe_n_q <= 1'b1;
            dac_q    <= MID;
            valid_q  <= 1'b0;
            ucnt_q   <= '0;
            rate_q   <= '0;
            clr_q    <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            slrd_n_q <= slrd_n_d;
            sloe_n_q <= sloe_n_d;
            dac_q    <= dac_d;
            valid_q  <= valid_d;
            ucnt_q   <= ucnt_d;
            rate_q   <= rate_d;
            clr_q    <= cfg_ctrl[CTRL_CLEAR_BIT];
            status_q <= status_d;
        end
    end

    assign fx2_slrd_n  = slrd_n_q;
    assign fx2_sloe_n  = sloe_n_q;
    assign fx2_fifoadr = FX2_EP;
    assign dac_data    = dac_q;
    assign dac_valid   = valid_q;
    assign status      = status_q;

endmodule

// File: tb/tb_fx2_dac_sequencer.sv
// Testbench for fx2_dac_sequencer: emulates the FX2 endpoint as a word queue
// and checks every cycle against a queue-based behavioural model.
module tb_fx2_dac_sequencer;

    localparam int          DEPTH = 16;
    localparam logic [13:0] MID   = 14'h2000;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_rate;
    logic        fx2_empty_n;
    logic [15:0] fx2_fd;
    logic        fx2_slrd_n;
    logic        fx2_sloe_n;
    logic [1:0]  fx2_fifoadr;
    logic [13:0] dac_data;
    logic        dac_valid;
    logic [31:0] status;

    fx2_dac_sequencer #(
        .DAC_W      (14),
        .FIFO_DEPTH (16),
        .RATE_W     (24),
        .FX2_EP     (2'b10)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_rate    (cfg_rate),
        .fx2_empty_n (fx2_empty_n),
        .fx2_fd      (fx2_fd),
        .fx2_slrd_n  (fx2_slrd_n),
        .fx2_sloe_n  (fx2_sloe_n),
        .fx2_fifoadr (fx2_fifoadr),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid),
        .status      (status)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_state;
    logic [13:0] m_q[$];
    int          m_ucnt;
    logic [13:0] m_dac;
    bit          m_valid;
    bit          m_slrd;
    bit          m_sloe;
    bit          m_clr_prev;
    int          m_age;
    int          m_per;
    logic [31:0] m_status;

    // FX2 endpoint emulation
    logic [15:0] src_q[$];
    bit          fx_gate;
    bit          slrd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] conv(input logic [13:0] w);
`ifdef SIGNED_INPUT_EN
        return w ^ 14'h2000;
`else
        return w;
`endif
    endfunction

    task automatic drive_fx2();
        fx2_fd      = (src_q.size() > 0) ? src_q[0] : 16'h0BAD;
        fx2_empty_n = fx_gate && (src_q.size() > 0);
    endtask

    // Applies the rules for one clock edge using the inputs present before it.
    task automatic model_edge();
        bit          en, hold, clr, rise, push, start_read, tick;
        int          thr;
        logic [13:0] w;
        if (reset_reset) begin
            m_state = 0; m_q.delete(); m_ucnt = 0; m_dac = MID; m_valid = 0;
            m_slrd = 1; m_sloe = 1; m_clr_prev = 0; m_age = 0; m_status = '0;
            return;
        end
        en   = cfg_ctrl[0];
        hold = cfg_ctrl[1];
        clr  = cfg_ctrl[2];
        rise = clr && !m_clr_prev;
        m_clr_prev = clr;
        thr = int'(cfg_ctrl[15:8]);
        if (thr == 0) thr = 1;
        if (thr > DEPTH) thr = DEPTH;
        m_valid = 0;
        if (!en) begin
            m_state = 0; m_q.delete(); m_dac = MID; m_slrd = 1;
        end else if (m_state == 0) begin
            m_state = 1; m_dac = MID; m_slrd = 1;
        end else begin
            push       = !m_slrd;
            start_read = m_slrd && fx2_empty_n && (DEPTH - m_q.size() >= 2);
            if (m_state == 1) begin
                if (m_q.size() >= thr) begin
                    m_state = 2; m_age = 0; m_per = int'(cfg_rate[23:0]) + 1;
                end
            end else begin
                tick = (m_age % m_per) == (m_per - 1);
                m_age++;
                if (tick) begin
                    m_valid = 1;
                    if (m_q.size() > 0) begin
                        w = m_q.pop_front();
                        m_dac = conv(w);
                        m_state = 2;
                    end else begin
                        m_state = 3;
                        if (m_ucnt < 65535) m_ucnt++;
                        if (!hold) m_dac = MID;
                    end
                end
            end
            if (push) m_q.push_back(fx2_fd[15 -: 14]);
            m_slrd = !start_read;
        end
        if (rise) m_ucnt = 0;
        m_sloe   = (m_state == 0);
        m_status = {16'(m_ucnt), 12'h000, (m_q.size() == DEPTH), (m_q.size() == 0), 2'(m_state)};
    endtask

    task automatic cycle();
        @(posedge clk_clk);
        model_edge();
        #1;
        chk("slrd_n",    32'(fx2_slrd_n), 32'(m_slrd));
        chk("sloe_n",    32'(fx2_sloe_n), 32'(m_sloe));
        chk("dac_valid", 32'(dac_valid),  32'(m_valid));
        chk("dac_data",  32'(dac_data),   32'(m_dac));
        chk("status",    status,          m_status);
        chk("slrd_gap",  32'(!fx2_slrd_n && !slrd_seen), 32'd0);
        if (!slrd_seen && src_q.size() > 0) src_q.delete(0);
        slrd_seen = fx2_slrd_n;
        drive_fx2();
    endtask

    task automatic disable_seq();
        cfg_ctrl[0] = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        slrd_seen   = 1'b1;
        reset_reset = 1'b1;
        cfg_rate    = 32'd3;
        cfg_ctrl    = {16'h0, 8'd4, 5'b0, 3'b001};
        fx_gate     = 1'b1;
        for (int k = 1; k <= 40; k++) src_q.push_back(16'(4 * k));
        drive_fx2();

        // Reset held with enable and data available
        for (int i = 0; i < 4; i++) cycle();
        chk("fifoadr", 32'(fx2_fifoadr), 32'h2);
        reset_reset = 1'b0;

        // Paced output, rate 3, threshold 4
        for (int i = 0; i < 110; i++) cycle();

        // Back-to-back samples then underrun with hold_last
        disable_seq();
        src_q.delete();
        for (int k = 0; k < 7; k++) src_q.push_back(16'($urandom));
        src_q.push_back(16'h8000);
        drive_fx2();
        cfg_rate = 32'd0;
        cfg_ctrl = {16'h0, 8'd8, 5'b0, 3'b011};
        for (int i = 0; i < 40; i++) cycle();
        chk("underrun_state", 32'(status[1:0]), 32'd3);
        cfg_ctrl[1] = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("underrun_mid", 32'(dac_data), 32'(MID));

        // Refill: return to RUN
        for (int k = 0; k < 4; k++) src_q.push_back(16'($urandom));
        drive_fx2();
        for (int i = 0; i < 20; i++) cycle();

        // Clear coinciding with an underrun tick
        cfg_ctrl[2] = 1'b1; cycle();
        cfg_ctrl[2] = 1'b0; cycle();
        for (int i = 0; i < 200 && m_ucnt != 5; i++) cycle();
        chk("ucnt_five", 32'(status[31:16]), 32'd5);
        cfg_ctrl[2] = 1'b1; cycle();
        chk("ucnt_clr", 32'(status[31:16]), 32'd0);
        cfg_ctrl[2] = 1'b0; cycle();

        // Randomized blocks
        for (int blk = 0; blk < 12; blk++) begin
            disable_seq();
            if (blk == 6) begin
                reset_reset = 1'b1; cycle();
                reset_reset = 1'b0;
            end
            cfg_rate = 32'($urandom_range(0, 6));
            cfg_ctrl = {16'h0, 8'($urandom_range(0, 20)), 5'b0, 1'b0,
                        1'($urandom_range(0, 1)), 1'b1};
            for (int c = 0; c < 200; c++) begin
                if (src_q.size() < 6 && $urandom_range(0, 3) != 0) src_q.push_back(16'($urandom));
                fx_gate     = ($urandom_range(0, 9) < 8);
                cfg_ctrl[2] = ($urandom_range(0, 19) == 0);
                if (blk == 3 && c == 100) reset_reset = 1'b1;
                else reset_reset = 1'b0;
                drive_fx2();
                cycle();
            end
            reset_reset = 1'b0;
        end

        // Underrun counter saturation
        disable_seq();
        src_q.delete();
        src_q.push_back(16'h1234);
        fx_gate  = 1'b1;
        drive_fx2();
        cfg_rate = 32'd0;
        cfg_ctrl = {16'h0, 8'd1, 5'b0, 3'b001};
        for (int i = 0; i < 65600; i++) cycle();
        chk("ucnt_sat", 32'(status[31:16]), 32'hFFFF);

        // Disable in RUN with 10 words buffered
        disable_seq();
        src_q.delete();
        for (int k = 0; k < 10; k++) src_q.push_back(16'($urandom));
        drive_fx2();
        cfg_rate = 32'd1000;
        cfg_ctrl = {16'h0, 8'd10, 5'b0, 3'b001};
        for (int i = 0; i < 30; i++) cycle();
        chk("run_before_dis", 32'(status[1:0]), 32'd2);
        for (int k = 0; k < 6; k++) src_q.push_back(16'($urandom));
        drive_fx2();
        cfg_ctrl[0] = 1'b0;
        cycle();
        chk("dis_idle",  32'(status[1:0]), 32'd0);
        chk("dis_empty", 32'(status[2]),   32'd1);
        chk("dis_mid",   32'(dac_data),    32'(MID));
        for (int i = 0; i < 10; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
